// File: rtl/sigmoid_arbiter.sv
// sigmoid_arbiter: round-robin sharing of one sigmoid ROM among the neurons of a layer,
// collecting each neuron's activation and pulsing layer_done once every neuron is served.
module sigmoid_arbiter #(
    parameter int NUM_NEURONS = 4,
    parameter int inWidth     = 5,
    parameter int dataWidth   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_NEURONS-1:0]           req,
    input  logic [NUM_NEURONS*inWidth-1:0]   sum_in,
    output logic [NUM_NEURONS-1:0]           ack,
    output logic                             rom_in_val,
    output logic [inWidth-1:0]               rom_sig_in,
    input  logic [dataWidth-1:0]             rom_sig_out,
    output logic [NUM_NEURONS-1:0]           res_valid,
    output logic [NUM_NEURONS*dataWidth-1:0] res_data,
    output logic                             layer_done,
    output logic                             busy
);
    localparam int PW = $clog2(NUM_NEURONS);

    logic [PW-1:0]          ptr, tag, gnt;
    logic                   fly, found, done_now;
    logic [NUM_NEURONS-1:0] elig, tag_oh, next_valid;

    // Scan from the far end toward ptr so the last hit is the first eligible after ptr.
    always_comb begin
        tag_oh = fly ? NUM_NEURONS'(1) << tag : '0;
        elig = req & ~res_valid & ~tag_oh;
        found = 1'b0;
        gnt = '0;
        for (int k = NUM_NEURONS - 1; k >= 0; k--) begin
            if (elig[(int'(ptr) + k) % NUM_NEURONS] && !start) begin
                found = 1'b1;
                gnt = PW'((int'(ptr) + k) % NUM_NEURONS);
            end
        end
        ack = found ? NUM_NEURONS'(1) << gnt : '0;
        rom_in_val = found;
        rom_sig_in = found ? sum_in[int'(gnt)*inWidth +: inWidth] : '0;
        next_valid = res_valid | tag_oh;
        done_now = busy & (&next_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            tag        <= '0;
            fly        <= 1'b0;
            res_valid  <= '0;
            res_data   <= '0;
            layer_done <= 1'b0;
            busy       <= 1'b0;
        end else if (start) begin
            ptr        <= '0;
            fly        <= 1'b0;
            res_valid  <= '0;
            layer_done <= 1'b0;
            busy       <= 1'b1;
        end else begin
            if (fly)
                res_data[int'(tag)*dataWidth +: dataWidth] <= rom_sig_out;
            res_valid  <= next_valid;
            fly        <= found;
            if (found) begin
                ptr <= (int'(gnt) == NUM_NEURONS - 1) ? '0 : gnt + 1'b1;
                tag <= gnt;
            end
            layer_done <= done_now;
            if (done_now)
                busy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sigmoid_arbiter.sv
// tb_sigmoid_arbiter: scoreboard bench for sigmoid_arbiter with a table[k]=k ROM model
// indexed by (sum+16) mod 32, one-cycle read latency.
module tb_sigmoid_arbiter;
    localparam int N = 4, IW = 5, DW = 16;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [N-1:0] req = '0;
    logic [IW-1:0] sums [N];
    logic [N*IW-1:0] sum_in;
    logic [N-1:0] ack, res_valid;
    logic rom_in_val, layer_done, busy;
    logic [IW-1:0] rom_sig_in;
    logic [IW-1:0] rom_idx = '0;
    logic [DW-1:0] rom_sig_out;
    logic [N*DW-1:0] res_data;
    int errors = 0, checks = 0, cyc = 0;
    int ord [N];

    typedef struct {int idx; logic [DW-1:0] d; int c;} exp_t;
    exp_t sb [$];

    sigmoid_arbiter #(.NUM_NEURONS(N), .inWidth(IW), .dataWidth(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .req(req), .sum_in(sum_in), .ack(ack),
        .rom_in_val(rom_in_val), .rom_sig_in(rom_sig_in), .rom_sig_out(rom_sig_out),
        .res_valid(res_valid), .res_data(res_data), .layer_done(layer_done), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rom_in_val) rom_idx <= rom_sig_in + 5'd16;
    end
    assign rom_sig_out = DW'(rom_idx);

    for (genvar g = 0; g < N; g++) assign sum_in[g*IW +: IW] = sums[g];

    function automatic logic [DW-1:0] rom_model(input logic [IW-1:0] s);
        logic [IW-1:0] i;
        i = s + 5'd16;
        return DW'(i);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== '0 || rom_in_val !== 1'b0) begin
            errors++;
            $display("FAIL start_blocks_grant ack=%b rom_in_val=%b expected 0000/0", ack, rom_in_val);
        end
        tick;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || res_valid !== '0) begin
            errors++;
            $display("FAIL start_state busy=%b res_valid=%b expected 1/0000", busy, res_valid);
        end
    endtask

    // Expects the grants listed in ord[0..n-1]; scoreboard pairs each ack with its capture.
    task automatic run_pass(input int n, input bit exp_done);
        int k = 0, dones = 0;
        logic [N-1:0] prev, nv, a;
        exp_t e;
        prev = res_valid;
        for (int c = 0; c < n + 4; c++) begin
            @(negedge clk);
            nv = res_valid & ~prev;
            prev = res_valid;
            if (nv != '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result res_valid=%b expected no new bit", res_valid);
                end else begin
                    e = sb.pop_front();
                    if (nv !== N'(1) << e.idx || cyc - e.c != 2 || res_data[e.idx*DW +: DW] !== e.d) begin
                        errors++;
                        $display("FAIL result new_valid=%b latency=%0d data=%0d expected bit %0d latency 2 data=%0d",
                                 nv, cyc - e.c, res_data[e.idx*DW +: DW], e.idx, e.d);
                    end
                end
            end
            if (layer_done) begin
                dones++;
                checks++;
                if (res_valid !== '1) begin
                    errors++;
                    $display("FAIL done_with_all res_valid=%b expected 1111", res_valid);
                end
            end
            a = ack;
            if (ack != '0) begin
                checks++;
                if (k >= n || ack !== N'(1) << ord[k] || rom_sig_in !== sums[ord[k]] || rom_in_val !== 1'b1) begin
                    errors++;
                    $display("FAIL grant ack=%b sig_in=%0d expected neuron %0d sig_in=%0d",
                             ack, rom_sig_in, (k < n) ? ord[k] : -1, (k < n) ? sums[ord[k]] : 0);
                end else begin
                    sb.push_back('{ord[k], rom_model(sums[ord[k]]), cyc});
                end
                k++;
            end
            tick;
            req = req & ~a;
        end
        checks++;
        if (k != n || sb.size() != 0 || dones != int'(exp_done) || busy !== !exp_done) begin
            errors++;
            $display("FAIL pass_end grants=%0d pending=%0d dones=%0d busy=%b expected %0d/0/%0d/%b",
                     k, sb.size(), dones, busy, n, int'(exp_done), !exp_done);
        end
        sb.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = '0;
        tick;
        tick;
        @(negedge clk);
        checks++;
        if (res_valid !== '0 || res_data !== '0) begin
            errors++;
            $display("FAIL reset_results res_valid=%b res_data=%h expected 0", res_valid, res_data);
        end
        checks++;
        if (layer_done !== 1'b0 || busy !== 1'b0 || ack !== '0 || rom_in_val !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl done=%b busy=%b ack=%b in_val=%b expected 0", layer_done, busy, ack, rom_in_val);
        end
        tick;
        rst = 1'b0;
    endtask

    task automatic test_single;
        sums[0] = 5'd3;
        req = 4'b0001;
        do_start;
        ord[0] = 0;
        run_pass(1, 1'b0);
    endtask

    task automatic test_all;
        sums[0] = 5'd3;
        sums[1] = 5'h1E;
        sums[2] = 5'd0;
        sums[3] = 5'd7;
        req = 4'b1111;
        do_start;
        ord = '{0, 1, 2, 3};
        run_pass(4, 1'b1);
    endtask

    task automatic test_fairness;
        req = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ack !== '0 || rom_in_val !== 1'b0) begin
                errors++;
                $display("FAIL served_masked ack=%b in_val=%b expected 0000/0", ack, rom_in_val);
            end
            tick;
        end
        req = 4'b0010;
        do_start;
        ord[0] = 1;
        run_pass(1, 1'b0);
        req = 4'b1111;
        ord = '{2, 3, 0, 0};
        run_pass(3, 1'b1);
    endtask

    task automatic test_start_collision;
        sums[1] = 5'd5;
        req = 4'b0010;
        do_start;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0010) begin
            errors++;
            $display("FAIL collide_first_grant ack=%b expected 0010", ack);
        end
        tick;
        req = 4'b0001;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== '0 || rom_in_val !== 1'b0) begin
            errors++;
            $display("FAIL collide_no_ack ack=%b in_val=%b expected 0000/0", ack, rom_in_val);
        end
        tick;
        start = 1'b0;
        checks++;
        if (res_valid !== '0 || res_data[1*DW +: DW] !== 16'd14) begin
            errors++;
            $display("FAIL collide_dropped res_valid=%b data1=%0d expected 0000/14", res_valid, res_data[1*DW +: DW]);
        end
        @(negedge clk);
        checks++;
        if (ack !== 4'b0001 || rom_sig_in !== 5'd3) begin
            errors++;
            $display("FAIL collide_next_grant ack=%b sig_in=%0d expected 0001/3", ack, rom_sig_in);
        end
        tick;
        req = '0;
        tick;
        @(negedge clk);
        checks++;
        if (res_valid !== 4'b0001 || res_data[0 +: DW] !== 16'd19) begin
            errors++;
            $display("FAIL collide_capture res_valid=%b data0=%0d expected 0001/19", res_valid, res_data[0 +: DW]);
        end
    endtask

    task automatic test_idle;
        logic [N-1:0] v;
        logic [N*DW-1:0] d;
        logic b;
        req = '0;
        v = res_valid;
        d = res_data;
        b = busy;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (ack !== '0 || rom_in_val !== 1'b0 || rom_sig_in !== '0 || res_valid !== v ||
                res_data !== d || busy !== b || layer_done !== 1'b0) begin
                errors++;
                $display("FAIL idle ack=%b in_val=%b sig_in=%0d valid=%b busy=%b expected 0000/0/0/%b/%b",
                         ack, rom_in_val, rom_sig_in, res_valid, busy, v, b);
            end
            tick;
        end
    endtask

    task automatic test_reset_mid_pass;
        int acks = 0;
        logic [N-1:0] a;
        sums[0] = 5'd1;
        sums[1] = 5'd2;
        sums[2] = 5'd4;
        sums[3] = 5'd6;
        req = 4'b1111;
        do_start;
        for (int c = 0; c < 6 && acks < 2; c++) begin
            @(negedge clk);
            a = ack;
            if (ack != '0) acks++;
            tick;
            req = req & ~a;
        end
        checks++;
        if (acks != 2) begin
            errors++;
            $display("FAIL midpass_grants got=%0d expected 2", acks);
        end
        rst = 1'b1;
        req = '0;
        tick;
        rst = 1'b0;
        checks++;
        if (res_valid !== '0 || res_data !== '0 || busy !== 1'b0 || layer_done !== 1'b0) begin
            errors++;
            $display("FAIL midpass_reset valid=%b data=%h busy=%b done=%b expected all 0",
                     res_valid, res_data, busy, layer_done);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (layer_done !== 1'b0 || res_valid !== '0) begin
                errors++;
                $display("FAIL midpass_quiet done=%b valid=%b expected 0/0000", layer_done, res_valid);
            end
            tick;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) sums[i] = '0;
        test_reset;
        test_single;
        test_all;
        test_fairness;
        test_start_collision;
        test_idle;
        test_reset_mid_pass;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish within 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
